// File: rtl/edm_buf_defs.sv
// Shared definitions for the EDM request buffers (RX and TX).
// DELIM marker byte, default frame width, FSM state encoding.
package edm_buf_defs;

  localparam logic [7:0] DELIM = 8'hee;
  localparam int DEF_WIDTH = 64;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  function automatic logic is_delim(input logic [7:0] b);
    return b == DELIM;
  endfunction

endpackage

// File: rtl/buf_mem.sv
// Frame storage: 2**DEPTH x WIDTH, one sync write, one async read.
// Ports: clk, we/w_addr/w_data (write), r_addr/r_data (read).
module buf_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [DEPTH-1:0] r_addr,
  output logic [WIDTH-1:0] r_data
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/req_rx_fifo_buf.sv
// RX request buffer: store-and-forward FIFO exposing only whole requests.
// Ports: clk, reset_n, wr/w_data in, rd/r_data out, empty, full, space, req_cnt, reqfin, drop.
module req_rx_fifo_buf
  import edm_buf_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             rd,
  output logic [WIDTH-1:0] r_data,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   space,
  output logic [DEPTH:0]   req_cnt,
  output logic             reqfin,
  output logic             drop
);

  localparam logic [DEPTH:0] CAP = (DEPTH+1)'(1) << DEPTH;
  localparam logic [DEPTH:0] ONE = (DEPTH+1)'(1);

  state_t state, state_n;

  logic [DEPTH:0] r_ptr, w_ptr, c_ptr;
  logic [DEPTH:0] used;
  logic rd_fire, wr_acc, ovf, commit;
  logic in_delim, head_delim, pop_delim;

  assign used    = w_ptr - r_ptr;
  assign empty   = (r_ptr == c_ptr);
  assign full    = (used == CAP);
  assign space   = CAP - used;
  assign rd_fire = rd & ~empty;

  assign in_delim   = is_delim(w_data[7:0]);
  assign head_delim = is_delim(r_data[7:0]);
  assign pop_delim  = rd_fire & head_delim;
  assign commit     = wr_acc & in_delim;

  buf_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (wr_acc),
    .w_addr (w_ptr[DEPTH-1:0]),
    .w_data (w_data),
    .r_addr (r_ptr[DEPTH-1:0]),
    .r_data (r_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_ACCEPT;
    else
      state <= state_n;
  end

  // A popped slot is reusable in the same cycle, so full
  // only blocks a write when nothing is being read.
  always_comb begin
    state_n = state;
    wr_acc  = 1'b0;
    ovf     = 1'b0;
    unique case (state)
      ST_ACCEPT: begin
        if (wr) begin
          if (!full || rd_fire) begin
            wr_acc = 1'b1;
          end else begin
            ovf = 1'b1;
            if (!in_delim)
              state_n = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (wr && in_delim)
          state_n = ST_ACCEPT;
      end
      default: state_n = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      w_ptr   <= '0;
      c_ptr   <= '0;
      req_cnt <= '0;
      reqfin  <= 1'b1;
      drop    <= 1'b0;
    end else begin
      drop <= ovf;
      if (rd_fire) begin
        r_ptr  <= r_ptr + ONE;
        reqfin <= head_delim;
      end
      // Overflow rewinds the speculative pointer, dropping
      // every frame of the partial request at once.
      if (ovf)
        w_ptr <= c_ptr;
      else if (wr_acc)
        w_ptr <= w_ptr + ONE;
      if (commit)
        c_ptr <= w_ptr + ONE;
      if (commit && !pop_delim)
        req_cnt <= req_cnt + ONE;
      else if (!commit && pop_delim)
        req_cnt <= req_cnt - ONE;
    end
  end

endmodule

// File: tb/tb_req_rx_fifo_buf.sv
// Bench for req_rx_fifo_buf: directed scenarios plus random traffic
// checked against a queue-based request model.
module tb_req_rx_fifo_buf;

  logic        clk;
  logic        reset_n;
  logic        wr;
  logic [63:0] w_data;
  logic        rd;
  logic [63:0] r_data;
  logic        empty;
  logic        full;
  logic [3:0]  space;
  logic [3:0]  req_cnt;
  logic        reqfin;
  logic        drop;

  int checks = 0;
  int failures = 0;
  string tag = "init";

  req_rx_fifo_buf #(
    .WIDTH(64),
    .DEPTH(3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .w_data  (w_data),
    .rd      (rd),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full),
    .space   (space),
    .req_cnt (req_cnt),
    .reqfin  (reqfin),
    .drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed frames, speculative frames, discard flag.
  logic [63:0] cq[$];
  logic [63:0] pq[$];
  bit m_disc;
  bit m_reqfin;
  bit m_drop;

  function automatic int m_reqs();
    int n = 0;
    foreach (cq[i])
      if (cq[i][7:0] == 8'hee) n++;
    return n;
  endfunction

  task automatic m_reset();
    cq.delete();
    pq.delete();
    m_disc = 0;
    m_reqfin = 1;
    m_drop = 0;
  endtask

  task automatic m_tick(input bit w, input logic [63:0] d, input bit r);
    bit fire;
    bit dl;
    logic [63:0] head;
    fire = r && (cq.size() > 0);
    head = fire ? cq[0] : 64'h0;
    dl = (d[7:0] == 8'hee);
    m_drop = 0;
    if (fire)
      void'(cq.pop_front());
    if (!m_disc) begin
      if (w) begin
        if ((cq.size() + pq.size() + (fire ? 1 : 0)) < 8 || fire) begin
          pq.push_back(d);
          if (dl) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
          end
        end else begin
          pq.delete();
          m_drop = 1;
          if (!dl) m_disc = 1;
        end
      end
    end else if (w && dl) begin
      m_disc = 0;
    end
    if (fire)
      m_reqfin = (head[7:0] == 8'hee);
  endtask

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s/%s observed=%h expected=%h", tag, nm, obs, exp);
    end
  endtask

  task automatic check_all();
    int tot;
    tot = cq.size() + pq.size();
    chk("empty", 64'(empty), 64'(cq.size() == 0));
    chk("full", 64'(full), 64'(tot == 8));
    chk("space", 64'(space), 64'(8 - tot));
    chk("req_cnt", 64'(req_cnt), 64'(m_reqs()));
    chk("reqfin", 64'(reqfin), 64'(m_reqfin));
    chk("drop", 64'(drop), 64'(m_drop));
    if (cq.size() > 0)
      chk("r_data", r_data, cq[0]);
  endtask

  task automatic step(input bit w, input logic [63:0] d, input bit r);
    wr = w;
    w_data = d;
    rd = r;
    @(posedge clk);
    m_tick(w, d, r);
    @(negedge clk);
    wr = 0;
    rd = 0;
    check_all();
  endtask

  // Assert reset between edges and check the async effect at once.
  task automatic do_reset();
    #2 reset_n = 0;
    #1 m_reset();
    check_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [63:0] rnd_frame(input bit dl);
    logic [63:0] f;
    f = {$urandom, $urandom};
    if (dl) f[7:0] = 8'hee;
    else if (f[7:0] == 8'hee) f[7:0] = 8'h00;
    return f;
  endfunction

  initial begin
    reset_n = 0;
    wr = 0;
    rd = 0;
    w_data = '0;
    m_reset();
    repeat (3) @(negedge clk);
    tag = "reset";
    check_all();
    reset_n = 1;

    tag = "reset_mid";
    for (int i = 0; i < 5; i++) step(1, 64'(i + 16), 0);
    chk("space5", 64'(space), 64'd3);
    do_reset();
    chk("empty_rst", 64'(empty), 64'd1);
    chk("space_rst", 64'(space), 64'd8);

    tag = "commit";
    step(1, 64'h01, 0);
    step(1, 64'h02, 0);
    chk("empty_pre", 64'(empty), 64'd1);
    step(1, 64'hee, 0);
    chk("empty_post", 64'(empty), 64'd0);
    chk("req1", 64'(req_cnt), 64'd1);
    chk("space_c", 64'(space), 64'd5);
    chk("rd0", r_data, 64'h01);
    step(0, 0, 1);
    chk("rf0", 64'(reqfin), 64'd0);
    chk("rd1", r_data, 64'h02);
    step(0, 0, 1);
    chk("rf1", 64'(reqfin), 64'd0);
    chk("rd2", r_data, 64'hee);
    step(0, 0, 1);
    chk("rf2", 64'(reqfin), 64'd1);
    chk("req0", 64'(req_cnt), 64'd0);
    chk("empty_d", 64'(empty), 64'd1);

    tag = "overflow";
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 64'(i + 32), 0);
    chk("full8", 64'(full), 64'd1);
    chk("empty8", 64'(empty), 64'd1);
    step(1, 64'h41, 0);
    chk("drop1", 64'(drop), 64'd1);
    chk("space8", 64'(space), 64'd8);
    step(1, 64'h42, 0);
    chk("drop0", 64'(drop), 64'd0);
    step(1, 64'h43, 0);
    step(1, 64'hee, 0);
    chk("disc_sp", 64'(space), 64'd8);
    step(1, 64'h05, 0);
    step(1, 64'h1ee, 0);
    chk("req_ov", 64'(req_cnt), 64'd1);
    chk("rd_ov", r_data, 64'h05);

    tag = "full_rdwr";
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 64'(i + 48), 0);
    step(1, 64'h2ee, 0);
    chk("full_c", 64'(full), 64'd1);
    chk("req_f", 64'(req_cnt), 64'd1);
    step(1, 64'haa, 1);
    chk("space0", 64'(space), 64'd0);
    chk("nodrop", 64'(drop), 64'd0);

    tag = "wrap";
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, {48'h0, 8'(i), 8'hee}, 0);
      chk("wrap_d", 64'(r_data[15:8]), 64'(i));
      step(0, 0, 1);
    end
    chk("wrap_req", 64'(req_cnt), 64'd0);
    chk("wrap_rf", 64'(reqfin), 64'd1);

    tag = "spurious";
    step(0, 0, 1);
    step(1, 64'h71, 0);
    step(1, 64'h72, 0);
    step(0, 0, 1);
    chk("sp_space", 64'(space), 64'd6);
    chk("sp_empty", 64'(empty), 64'd1);
    step(1, 64'h3ee, 0);

    tag = "random";
    for (int i = 0; i < 600; i++) begin
      bit w, r, dl;
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 55));
      dl = ($urandom_range(0, 99) < (((i / 150) % 2 == 0) ? 25 : 8));
      step(w, rnd_frame(dl), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
